// File: rtl/player_port_ctrl.sv
// Player-side port to the card dealer: issues one command at a time, waits for
// the dealer's acknowledge (with timeout), and keeps the hand of received cards.
module player_port_ctrl #(
    parameter int         HAND_SIZE   = 5,
    parameter int         CARD_W      = 6,
    parameter int         DATA_W      = 8,
    parameter int         ACK_TIMEOUT = 16,
    parameter logic [2:0] GET_CARD    = 3'b100
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               trigger,
    input  logic [2:0]                         action_code,
    input  logic [DATA_W-1:0]                  tx_data,
    input  logic                               clear_hand,
    input  logic                               cr_ack,
    input  logic [DATA_W-1:0]                  cr_rdata,
    output logic [2:0]                         cr_cmd,
    output logic                               cr_cmdvld,
    output logic [DATA_W-1:0]                  cr_wdata,
    output logic                               busy,
    output logic                               cmd_done,
    output logic                               cmd_err,
    output logic [$clog2(HAND_SIZE+1)-1:0]     card_count,
    output logic                               hand_full,
    output logic [HAND_SIZE*CARD_W-1:0]        hand_flat
);

    localparam int CNT_W  = $clog2(HAND_SIZE + 1);
    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        ERR
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    // Only the low CARD_W bits of the dealer data form a card.
    logic unused_rdata;
    assign unused_rdata = ^cr_rdata;

    assign hand_full = (card_count == CNT_W'(HAND_SIZE));

    // cr_cmd / cr_wdata double as the latched command, so they are zero outside REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            cr_cmd     <= '0;
            cr_cmdvld  <= 1'b0;
            cr_wdata   <= '0;
            busy       <= 1'b0;
            cmd_done   <= 1'b0;
            cmd_err    <= 1'b0;
            card_count <= '0;
            hand_flat  <= '0;
        end else begin
            cmd_done <= 1'b0;
            cmd_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        busy <= 1'b1;
                        if (action_code == GET_CARD && hand_full) begin
                            state   <= ERR;
                            cmd_err <= 1'b1;
                        end else begin
                            state     <= REQ;
                            cr_cmdvld <= 1'b1;
                            cr_cmd    <= action_code;
                            cr_wdata  <= tx_data;
                            wait_cnt  <= '0;
                        end
                    end
                end
                REQ: begin
                    if (cr_ack) begin
                        state     <= DONE;
                        cmd_done  <= 1'b1;
                        cr_cmdvld <= 1'b0;
                        cr_cmd    <= '0;
                        cr_wdata  <= '0;
                        if (cr_cmd == GET_CARD && !hand_full) begin
                            for (int i = 0; i < HAND_SIZE; i++) begin
                                if (card_count == CNT_W'(i)) begin
                                    hand_flat[i*CARD_W +: CARD_W] <= cr_rdata[CARD_W-1:0];
                                end
                            end
                            card_count <= card_count + CNT_W'(1);
                        end
                    end else if (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1)) begin
                        state     <= ERR;
                        cmd_err   <= 1'b1;
                        cr_cmdvld <= 1'b0;
                        cr_cmd    <= '0;
                        cr_wdata  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DONE, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Placed last so it overrides a capture on the same edge.
            if (clear_hand) begin
                hand_flat  <= '0;
                card_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_player_port_ctrl.sv
// Self-checking bench for player_port_ctrl: randomized commands checked against
// a queue-based model of the hand and a delay-based model of command outcome.
module tb_player_port_ctrl;

    localparam int         HAND_SIZE   = 5;
    localparam int         CARD_W      = 6;
    localparam int         DATA_W      = 8;
    localparam int         ACK_TIMEOUT = 16;
    localparam logic [2:0] GET_CARD    = 3'b100;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        trigger;
    logic [2:0]                  action_code;
    logic [DATA_W-1:0]           tx_data;
    logic                        clear_hand;
    logic                        cr_ack;
    logic [DATA_W-1:0]           cr_rdata;
    logic [2:0]                  cr_cmd;
    logic                        cr_cmdvld;
    logic [DATA_W-1:0]           cr_wdata;
    logic                        busy;
    logic                        cmd_done;
    logic                        cmd_err;
    logic [2:0]                  card_count;
    logic                        hand_full;
    logic [HAND_SIZE*CARD_W-1:0] hand_flat;

    int passed = 0;
    int total  = 0;
    logic [CARD_W-1:0] model_hand[$];

    player_port_ctrl #(
        .HAND_SIZE(HAND_SIZE), .CARD_W(CARD_W), .DATA_W(DATA_W),
        .ACK_TIMEOUT(ACK_TIMEOUT), .GET_CARD(GET_CARD)
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .action_code(action_code),
        .tx_data(tx_data), .clear_hand(clear_hand), .cr_ack(cr_ack),
        .cr_rdata(cr_rdata), .cr_cmd(cr_cmd), .cr_cmdvld(cr_cmdvld),
        .cr_wdata(cr_wdata), .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .card_count(card_count), .hand_full(hand_full), .hand_flat(hand_flat)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [HAND_SIZE*CARD_W-1:0] model_flat();
        logic [HAND_SIZE*CARD_W-1:0] f = '0;
        foreach (model_hand[i]) f[i*CARD_W +: CARD_W] = model_hand[i];
        return f;
    endfunction

    // Expected REQ length for a non-rejected command given the ack cycle.
    function automatic int exp_vld(input int ack_at);
        return (ack_at >= 1 && ack_at <= ACK_TIMEOUT) ? ack_at : ACK_TIMEOUT;
    endfunction

    function automatic int exp_ok(input int ack_at);
        return (ack_at >= 1 && ack_at <= ACK_TIMEOUT) ? 1 : 0;
    endfunction

    // Issues one command and observes it until busy drops; ack_at is the REQ
    // cycle (1-based) on which the dealer acks, out of range means never.
    task automatic run_cmd(input logic [2:0] code, input logic [DATA_W-1:0] data,
                           input int ack_at, input logic [DATA_W-1:0] rdata,
                           input bit noise, input bit clear_at_ack,
                           output int vld_cyc, output int done_n, output int err_n,
                           output int bad_hold, output int gap);
        int pulse_at = -100;
        vld_cyc = 0; done_n = 0; err_n = 0; bad_hold = 0; gap = -1;
        @(negedge clk);
        trigger = 1'b1; action_code = code; tx_data = data;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            trigger = 1'b0; cr_ack = 1'b0; clear_hand = 1'b0;
            cr_rdata = DATA_W'($urandom);
            if (cr_cmdvld) begin
                vld_cyc++;
                if (cr_cmd !== code || cr_wdata !== data) bad_hold++;
            end else if (cr_cmd !== 3'd0 || cr_wdata !== '0) begin
                bad_hold++;
            end
            if (cmd_done) begin done_n++; pulse_at = cyc; end
            if (cmd_err)  begin err_n++;  pulse_at = cyc; end
            if (!busy) begin
                gap = cyc - pulse_at;
                break;
            end
            if (cr_cmdvld && vld_cyc == ack_at) begin
                cr_ack = 1'b1; cr_rdata = rdata; clear_hand = clear_at_ack;
            end
            if (noise) begin
                trigger = 1'($urandom_range(0, 1));
                action_code = 3'($urandom);
                tx_data = DATA_W'($urandom);
            end
        end
        trigger = 1'b0; cr_ack = 1'b0; clear_hand = 1'b0; action_code = '0; tx_data = '0;
    endtask

    task automatic do_clear();
        @(negedge clk); clear_hand = 1'b1;
        @(negedge clk); clear_hand = 1'b0;
        model_hand.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; trigger = 0; action_code = 0; tx_data = 0; clear_hand = 0;
        cr_ack = 0; cr_rdata = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({cr_cmd, cr_cmdvld, cr_wdata, busy, cmd_done, cmd_err, card_count, hand_flat} !== '0)
            $display("[TB] FAIL reset_outputs: got cmd=%0h vld=%0b wdata=%0h busy=%0b cnt=%0d flat=%0h, required all 0",
                     cr_cmd, cr_cmdvld, cr_wdata, busy, card_count, hand_flat);
        else passed++;
        total++;
        if (hand_full !== 1'b0) $display("[TB] FAIL reset_hand_full: got %0b required 0", hand_full);
        else passed++;
        rst = 1'b0;
        model_hand.delete();
    endtask

    task automatic test_get_card_basic();
        int v, d, e, b, g;
        do_clear();
        run_cmd(GET_CARD, 8'h00, 3, 8'h2A, 0, 0, v, d, e, b, g);
        model_hand.push_back(6'h2A);
        total++; if (v !== 3) $display("[TB] FAIL basic_vld_cycles: got %0d required 3", v); else passed++;
        total++; if (d !== 1 || e !== 0) $display("[TB] FAIL basic_done: got done=%0d err=%0d required 1/0", d, e); else passed++;
        total++; if (hand_flat[5:0] !== 6'h2A) $display("[TB] FAIL basic_slot0: got %0h required 2a", hand_flat[5:0]); else passed++;
        total++; if (card_count !== 3'd1) $display("[TB] FAIL basic_count: got %0d required 1", card_count); else passed++;
        total++; if (g !== 1 || b !== 0) $display("[TB] FAIL basic_tail: got gap=%0d bad=%0d required 1/0", g, b); else passed++;
    endtask

    task automatic test_hand_full();
        int v, d, e, b, g;
        logic [HAND_SIZE*CARD_W-1:0] saved;
        logic [DATA_W-1:0] r;
        do_clear();
        for (int i = 0; i < HAND_SIZE; i++) begin
            r = DATA_W'($urandom);
            run_cmd(GET_CARD, 8'h00, 2, r, 0, 0, v, d, e, b, g);
            model_hand.push_back(r[CARD_W-1:0]);
        end
        total++; if (card_count !== 3'd5 || hand_full !== 1'b1)
            $display("[TB] FAIL full_count: got cnt=%0d full=%0b required 5/1", card_count, hand_full); else passed++;
        total++; if (hand_flat !== model_flat()) $display("[TB] FAIL full_flat: got %0h required %0h", hand_flat, model_flat()); else passed++;
        saved = hand_flat;
        run_cmd(GET_CARD, 8'h00, 1, 8'h3F, 0, 0, v, d, e, b, g);
        total++; if (e !== 1 || d !== 0) $display("[TB] FAIL full_reject: got err=%0d done=%0d required 1/0", e, d); else passed++;
        total++; if (v !== 0) $display("[TB] FAIL full_no_cmdvld: got %0d cycles required 0", v); else passed++;
        total++; if (hand_flat !== saved) $display("[TB] FAIL full_flat_kept: got %0h required %0h", hand_flat, saved); else passed++;
        total++; if (g !== 1) $display("[TB] FAIL full_busy_drop: got gap %0d required 1", g); else passed++;
    endtask

    task automatic test_timeout();
        int v, d, e, b, g;
        run_cmd(3'b010, 8'h40, 0, 8'h00, 0, 0, v, d, e, b, g);
        total++; if (v !== ACK_TIMEOUT) $display("[TB] FAIL timeout_vld: got %0d required %0d", v, ACK_TIMEOUT); else passed++;
        total++; if (b !== 0) $display("[TB] FAIL timeout_wdata_hold: got %0d bad cycles required 0", b); else passed++;
        total++; if (e !== 1 || d !== 0) $display("[TB] FAIL timeout_err: got err=%0d done=%0d required 1/0", e, d); else passed++;
        total++; if (g !== 1) $display("[TB] FAIL timeout_busy_drop: got gap %0d required 1", g); else passed++;
    endtask

    task automatic test_ack_last();
        int v, d, e, b, g;
        run_cmd(3'b001, 8'h17, ACK_TIMEOUT, 8'h00, 0, 0, v, d, e, b, g);
        total++; if (d !== 1 || e !== 0) $display("[TB] FAIL ack_last: got done=%0d err=%0d required 1/0", d, e); else passed++;
        total++; if (v !== ACK_TIMEOUT) $display("[TB] FAIL ack_last_vld: got %0d required %0d", v, ACK_TIMEOUT); else passed++;
    endtask

    task automatic test_trigger_while_busy();
        int v, d, e, b, g;
        logic [DATA_W-1:0] r;
        run_cmd(3'b011, 8'hC5, 5, 8'h00, 1, 0, v, d, e, b, g);
        total++; if (b !== 0) $display("[TB] FAIL busy_cmd_hold: got %0d bad cycles required 0", b); else passed++;
        total++; if (d !== 1 || v !== 5) $display("[TB] FAIL busy_done: got done=%0d vld=%0d required 1/5", d, v); else passed++;
        do_clear();
        r = DATA_W'($urandom);
        run_cmd(GET_CARD, 8'h00, 4, r, 1, 0, v, d, e, b, g);
        model_hand.push_back(r[CARD_W-1:0]);
        total++; if (card_count !== 3'd1 || hand_flat !== model_flat())
            $display("[TB] FAIL busy_single_card: got cnt=%0d flat=%0h required 1/%0h", card_count, hand_flat, model_flat()); else passed++;
    endtask

    task automatic test_ack_outside_req();
        int pulses = 0, busy_seen = 0;
        logic [HAND_SIZE*CARD_W-1:0] saved = hand_flat;
        logic [2:0] cnt = card_count;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cr_ack = 1'b1; cr_rdata = DATA_W'($urandom);
            pulses += int'(cmd_done) + int'(cmd_err);
            busy_seen += int'(busy);
        end
        @(negedge clk); cr_ack = 1'b0;
        pulses += int'(cmd_done) + int'(cmd_err);
        busy_seen += int'(busy);
        total++; if (pulses !== 0 || busy_seen !== 0)
            $display("[TB] FAIL stray_ack_state: got pulses=%0d busy=%0d required 0/0", pulses, busy_seen); else passed++;
        total++; if (card_count !== cnt || hand_flat !== saved)
            $display("[TB] FAIL stray_ack_hand: got cnt=%0d flat=%0h required %0d/%0h", card_count, hand_flat, cnt, saved); else passed++;
    endtask

    task automatic test_clear_with_ack();
        int v, d, e, b, g;
        run_cmd(GET_CARD, 8'h00, 2, 8'h11, 0, 0, v, d, e, b, g);
        run_cmd(GET_CARD, 8'h00, 2, 8'h22, 0, 1, v, d, e, b, g);
        model_hand.delete();
        total++; if (d !== 1) $display("[TB] FAIL clear_ack_done: got %0d pulses required 1", d); else passed++;
        total++; if (card_count !== 3'd0 || hand_flat !== '0)
            $display("[TB] FAIL clear_ack_hand: got cnt=%0d flat=%0h required 0/0", card_count, hand_flat); else passed++;
    endtask

    task automatic test_rst_mid_req();
        int pulses = 0, busy_seen = 0;
        int v, d, e, b, g;
        run_cmd(GET_CARD, 8'h00, 1, 8'h05, 0, 0, v, d, e, b, g);
        @(negedge clk);
        trigger = 1'b1; action_code = GET_CARD; tx_data = 8'h99;
        repeat (4) begin @(negedge clk); trigger = 1'b0; end
        rst = 1'b1; cr_ack = 1'b1; cr_rdata = 8'h3C;
        @(negedge clk);
        total++;
        if ({cr_cmd, cr_cmdvld, cr_wdata, busy, cmd_done, cmd_err, card_count, hand_flat, hand_full} !== '0)
            $display("[TB] FAIL rst_mid_req: got cmd=%0h vld=%0b wdata=%0h busy=%0b done=%0b err=%0b cnt=%0d flat=%0h, required all 0",
                     cr_cmd, cr_cmdvld, cr_wdata, busy, cmd_done, cmd_err, card_count, hand_flat);
        else passed++;
        rst = 1'b0; cr_ack = 1'b0;
        model_hand.delete();
        repeat (5) begin
            @(negedge clk);
            pulses += int'(cmd_done) + int'(cmd_err);
            busy_seen += int'(busy);
        end
        total++; if (pulses !== 0 || busy_seen !== 0)
            $display("[TB] FAIL rst_abandon: got pulses=%0d busy=%0d required 0/0", pulses, busy_seen); else passed++;
    endtask

    task automatic test_random_commands();
        int v, d, e, b, g, ack_at, ev, ed, ee;
        logic [2:0] code;
        logic [DATA_W-1:0] data, r;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 5) == 0) do_clear();
            code = ($urandom_range(0, 1) == 1) ? GET_CARD : 3'($urandom);
            data = DATA_W'($urandom);
            r = DATA_W'($urandom);
            ack_at = $urandom_range(1, ACK_TIMEOUT + 3);
            if (code == GET_CARD && model_hand.size() == HAND_SIZE) begin
                ev = 0; ed = 0; ee = 1;
            end else begin
                ev = exp_vld(ack_at); ed = exp_ok(ack_at); ee = 1 - ed;
            end
            run_cmd(code, data, ack_at, r, 1, 0, v, d, e, b, g);
            if (ed == 1 && code == GET_CARD && model_hand.size() < HAND_SIZE)
                model_hand.push_back(r[CARD_W-1:0]);
            total++; if (d !== ed || e !== ee)
                $display("[TB] FAIL rand%0d_outcome: got done=%0d err=%0d required %0d/%0d", n, d, e, ed, ee); else passed++;
            total++; if (v !== ev) $display("[TB] FAIL rand%0d_vld: got %0d required %0d", n, v, ev); else passed++;
            total++; if (b !== 0 || g !== 1)
                $display("[TB] FAIL rand%0d_hold: got bad=%0d gap=%0d required 0/1", n, b, g); else passed++;
            total++; if (card_count !== 3'(model_hand.size()) || hand_flat !== model_flat())
                $display("[TB] FAIL rand%0d_hand: got cnt=%0d flat=%0h required %0d/%0h",
                         n, card_count, hand_flat, model_hand.size(), model_flat()); else passed++;
            total++; if (hand_full !== (model_hand.size() == HAND_SIZE))
                $display("[TB] FAIL rand%0d_full: got %0b required %0b", n, hand_full, model_hand.size() == HAND_SIZE); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_get_card_basic();
        test_hand_full();
        test_timeout();
        test_ack_last();
        test_trigger_while_busy();
        test_ack_outside_req();
        test_clear_with_ack();
        test_rst_mid_req();
        test_random_commands();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
